rx_multislot: RTL and testbench

//  Parametrised NoC input-port receiver. Accepts flits on a 2-phase toggle channel and

---
 rtl/rx_multislot.sv | 122 ++++++++++++
 tb/tb_rx_multislot.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_multislot.sv
// NoC input-port receiver: toggle-handshake flit intake, circular packet slots,
// switch request for the oldest complete packet and random-access readout.
module rx_multislot #(
  parameter int DATA_W    = 8,
  parameter int DEST_W    = 3,
  parameter int PKT_LEN   = 8,
  parameter int NUM_SLOTS = 2,
  parameter int AW        = $clog2(PKT_LEN)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ch_req,
  input  logic [DATA_W-1:0] ch_flit,
  output logic              ch_ack,
  output logic              sw_req,
  output logic [DEST_W-1:0] sw_chnl,
  input  logic              sw_gnt,
  input  logic              sw_done,
  input  logic [AW-1:0]     buf_addr,
  output logic [DATA_W-1:0] buf_data,
  output logic              err
);

  localparam int PW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(PKT_LEN - 1);

  // slot state | meaning: EMPTY free, FILLING header stored, FULL awaiting grant, GRANTED being read
  typedef enum logic [1:0] {EMPTY, FILLING, FULL, GRANTED} slot_e;

  slot_e             slot_q [NUM_SLOTS];
  slot_e             slot_d [NUM_SLOTS];
  logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [AW-1:0]     idx_q, idx_d, we_idx;
  logic              ack_q, ack_d, err_q, err_d, we;
  logic [DATA_W-1:0] mem [NUM_SLOTS][PKT_LEN];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (NUM_SLOTS == 1) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    slot_d = slot_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    idx_d  = idx_q;
    ack_d  = ack_q;
    err_d  = err_q;
    we     = 1'b0;
    we_idx = '0;

    // Write side only touches EMPTY/FILLING slots, read side only FULL/GRANTED,
    // so both may act in the same cycle without colliding.
    if ((ch_req != ack_q) && (slot_q[wr_q] == EMPTY || slot_q[wr_q] == FILLING)) begin
      ack_d = ch_req;
      if (idx_q == '0) begin
        if (ch_flit[DATA_W-1]) begin
          we             = 1'b1;
          slot_d[wr_q]   = FILLING;
          idx_d          = AW'(1);
        end else begin
          err_d = 1'b1;
        end
      end else if (ch_flit[DATA_W-1]) begin
        err_d = 1'b1;
        we    = 1'b1;
        idx_d = AW'(1);
      end else begin
        we     = 1'b1;
        we_idx = idx_q;
        if (idx_q == LAST_IDX) begin
          slot_d[wr_q] = FULL;
          wr_d         = ptr_inc(wr_q);
          idx_d        = '0;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
    end

    case (slot_q[rd_q])
      FULL:    if (sw_gnt) slot_d[rd_q] = GRANTED;
      GRANTED: if (sw_done) begin
        slot_d[rd_q] = EMPTY;
        rd_d         = ptr_inc(rd_q);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < NUM_SLOTS; s++) slot_q[s] <= EMPTY;
      wr_q  <= '0;
      rd_q  <= '0;
      idx_q <= '0;
      ack_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      slot_q <= slot_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      idx_q  <= idx_d;
      ack_q  <= ack_d;
      err_q  <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[wr_q][we_idx] <= ch_flit;
  end

  assign ch_ack  = ack_q;
  assign err     = err_q;
  assign sw_req  = (slot_q[rd_q] == FULL);
  assign sw_chnl = sw_req ? mem[rd_q][0][DEST_W-1:0] : '0;

  always_comb begin
    buf_data = '0;
    if (int'(buf_addr) < PKT_LEN) buf_data = mem[rd_q][buf_addr];
  end

endmodule

// File: tb/tb_rx_multislot.sv
// Bench for rx_multislot: directed scenarios plus a randomized flit stream checked
// against a queue-based packet framing model.
module tb_rx_multislot;

  localparam int DATA_W    = 8;
  localparam int DEST_W    = 3;
  localparam int PKT_LEN   = 8;
  localparam int NUM_SLOTS = 2;
  localparam int AW        = 3;

  typedef logic [7:0] flit_q_t[$];

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              ch_req = 1'b0;
  logic [DATA_W-1:0] ch_flit = '0;
  logic              ch_ack;
  logic              sw_req;
  logic [DEST_W-1:0] sw_chnl;
  logic              sw_gnt = 1'b0;
  logic              sw_done = 1'b0;
  logic [AW-1:0]     buf_addr = '0;
  logic [DATA_W-1:0] buf_data;
  logic              err;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] rd_buf [PKT_LEN];

  always #5 clk = ~clk;

  rx_multislot #(.DATA_W(DATA_W), .DEST_W(DEST_W), .PKT_LEN(PKT_LEN),
                 .NUM_SLOTS(NUM_SLOTS), .AW(AW)) dut (
    .clk(clk), .reset(reset), .ch_req(ch_req), .ch_flit(ch_flit), .ch_ack(ch_ack),
    .sw_req(sw_req), .sw_chnl(sw_chnl), .sw_gnt(sw_gnt), .sw_done(sw_done),
    .buf_addr(buf_addr), .buf_data(buf_data), .err(err)
  );

  task automatic do_reset();
    reset = 1'b1; ch_req = 1'b0; ch_flit = '0;
    sw_gnt = 1'b0; sw_done = 1'b0; buf_addr = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_flit(input logic [7:0] f, input int budget, output bit ok);
    @(negedge clk);
    ch_flit = f;
    ch_req  = ~ch_req;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (ch_ack === ch_req) begin ok = 1'b1; break; end
    end
  endtask

  task automatic send_seq(input flit_q_t q, output int n_ok);
    bit ok;
    n_ok = 0;
    foreach (q[i]) begin
      send_flit(q[i], 50, ok);
      if (!ok) break;
      n_ok++;
    end
  endtask

  function automatic flit_q_t make_pkt(input logic [7:0] hdr, input logic [7:0] first_body);
    flit_q_t q;
    q.push_back(hdr);
    for (int i = 1; i < PKT_LEN; i++) q.push_back(first_body + 8'(i - 1));
    return q;
  endfunction

  task automatic pulse_gnt();
    @(negedge clk); sw_gnt = 1'b1;
    @(negedge clk); sw_gnt = 1'b0;
  endtask

  task automatic pulse_done();
    @(negedge clk); sw_done = 1'b1;
    @(negedge clk); sw_done = 1'b0;
  endtask

  task automatic read_pkt();
    for (int a = 0; a < PKT_LEN; a++) begin
      @(negedge clk);
      buf_addr = AW'(a);
      #1;
      rd_buf[a] = buf_data;
    end
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({ch_ack, sw_req, sw_chnl, err} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_state: ack/req/chnl/err=%b required 000000", {ch_ack, sw_req, sw_chnl, err});
    end
  endtask

  task automatic test_single_packet();
    flit_q_t p;
    int n;
    do_reset();
    p = make_pkt(8'h85, 8'h01);
    send_seq(p, n);
    vectors++;
    if (n !== PKT_LEN) begin miscompares++; $display("FAIL t1_acks: got %0d required %0d", n, PKT_LEN); end
    vectors++;
    if (sw_req !== 1'b1 || sw_chnl !== 3'd5 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL t1_req: req=%b chnl=%0d err=%b required 1 5 0", sw_req, sw_chnl, err);
    end
    pulse_gnt();
    vectors++;
    if (sw_req !== 1'b0) begin miscompares++; $display("FAIL t1_req_drop: req=%b required 0", sw_req); end
    read_pkt();
    for (int a = 0; a < PKT_LEN; a++) begin
      vectors++;
      if (rd_buf[a] !== p[a]) begin
        miscompares++;
        $display("FAIL t1_data[%0d]: got %h required %h", a, rd_buf[a], p[a]);
      end
    end
    pulse_done();
    vectors++;
    if (sw_req !== 1'b0) begin miscompares++; $display("FAIL t1_after_done: req=%b required 0", sw_req); end
  endtask

  task automatic test_backpressure();
    flit_q_t pa, pb;
    int na, nb;
    logic ack0;
    bit stalled;
    do_reset();
    pa = make_pkt(8'h81, 8'h11);
    pb = make_pkt(8'h86, 8'h21);
    send_seq(pa, na);
    send_seq(pb, nb);
    vectors++;
    if (na + nb !== 2 * PKT_LEN) begin miscompares++; $display("FAIL t2_acks: got %0d required %0d", na + nb, 2 * PKT_LEN); end
    vectors++;
    if (sw_req !== 1'b1 || sw_chnl !== 3'd1) begin
      miscompares++; $display("FAIL t2_head: req=%b chnl=%0d required 1 1", sw_req, sw_chnl);
    end
    @(negedge clk);
    ch_flit = 8'h83;
    ch_req  = ~ch_req;
    ack0 = ch_ack;
    stalled = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (ch_ack !== ack0) stalled = 1'b0;
    end
    vectors++;
    if (!stalled) begin miscompares++; $display("FAIL t2_stall: ack toggled while full, required held"); end
    pulse_gnt();
    pulse_done();
    vectors++;
    if (ch_ack !== ack0 || sw_req !== 1'b1 || sw_chnl !== 3'd6) begin
      miscompares++;
      $display("FAIL t2_done_cycle: ack=%b req=%b chnl=%0d required %b 1 6", ch_ack, sw_req, sw_chnl, ack0);
    end
    @(negedge clk);
    vectors++;
    if (ch_ack !== ch_req) begin miscompares++; $display("FAIL t2_resume: ack=%b required %b", ch_ack, ch_req); end
  endtask

  task automatic test_bad_header();
    flit_q_t p;
    int n;
    bit ok;
    do_reset();
    send_flit(8'h00, 50, ok);
    vectors++;
    if (!ok || err !== 1'b1 || sw_req !== 1'b0) begin
      miscompares++; $display("FAIL t3_drop: acked=%b err=%b req=%b required 1 1 0", ok, err, sw_req);
    end
    p = make_pkt(8'h87, 8'h51);
    send_seq(p, n);
    vectors++;
    if (n !== PKT_LEN || sw_req !== 1'b1 || sw_chnl !== 3'd7 || err !== 1'b1) begin
      miscompares++;
      $display("FAIL t3_pkt: n=%0d req=%b chnl=%0d err=%b required 8 1 7 1", n, sw_req, sw_chnl, err);
    end
    pulse_gnt();
    read_pkt();
    for (int a = 0; a < PKT_LEN; a++) begin
      vectors++;
      if (rd_buf[a] !== p[a]) begin miscompares++; $display("FAIL t3_data[%0d]: got %h required %h", a, rd_buf[a], p[a]); end
    end
  endtask

  task automatic test_abandon();
    flit_q_t q, p;
    int n;
    do_reset();
    q = '{8'h82, 8'h31, 8'h32, 8'h33};
    send_seq(q, n);
    p = make_pkt(8'h84, 8'h41);
    send_seq(p, n);
    vectors++;
    if (err !== 1'b1 || sw_req !== 1'b1 || sw_chnl !== 3'd4) begin
      miscompares++; $display("FAIL t4_state: err=%b req=%b chnl=%0d required 1 1 4", err, sw_req, sw_chnl);
    end
    pulse_gnt();
    read_pkt();
    for (int a = 0; a < PKT_LEN; a++) begin
      vectors++;
      if (rd_buf[a] !== p[a]) begin miscompares++; $display("FAIL t4_data[%0d]: got %h required %h", a, rd_buf[a], p[a]); end
    end
  endtask

  task automatic test_reset_midstream();
    flit_q_t p, part;
    int n;
    bit ok;
    do_reset();
    send_flit(8'h00, 50, ok);
    p = make_pkt(8'h82, 8'h61);
    send_seq(p, n);
    pulse_gnt();
    part = '{8'h85, 8'h71, 8'h72, 8'h73};
    send_seq(part, n);
    @(negedge clk);
    reset = 1'b1;
    ch_req = 1'b0;
    #1;
    vectors++;
    if (sw_req !== 1'b0 || ch_ack !== 1'b0 || err !== 1'b0) begin
      miscompares++; $display("FAIL t5_async: req=%b ack=%b err=%b required 0 0 0", sw_req, ch_ack, err);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    p = make_pkt(8'h83, 8'h09);
    send_seq(p, n);
    vectors++;
    if (n !== PKT_LEN || sw_req !== 1'b1 || sw_chnl !== 3'd3 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL t5_fresh: n=%0d req=%b chnl=%0d err=%b required 8 1 3 0", n, sw_req, sw_chnl, err);
    end
    pulse_gnt();
    read_pkt();
    for (int a = 0; a < PKT_LEN; a++) begin
      vectors++;
      if (rd_buf[a] !== p[a]) begin miscompares++; $display("FAIL t5_data[%0d]: got %h required %h", a, rd_buf[a], p[a]); end
    end
  endtask

  task automatic test_ignored_handshake();
    flit_q_t p;
    int n;
    do_reset();
    pulse_gnt();
    p = make_pkt(8'h86, 8'h20);
    send_seq(p, n);
    vectors++;
    if (sw_req !== 1'b1) begin miscompares++; $display("FAIL t6_stray_gnt: req=%b required 1", sw_req); end
    pulse_done();
    repeat (2) @(negedge clk);
    vectors++;
    if (sw_req !== 1'b1 || sw_chnl !== 3'd6) begin
      miscompares++; $display("FAIL t6_early_done: req=%b chnl=%0d required 1 6", sw_req, sw_chnl);
    end
    pulse_gnt();
    vectors++;
    if (sw_req !== 1'b0) begin miscompares++; $display("FAIL t6_gnt: req=%b required 0", sw_req); end
  endtask

  task automatic test_random();
    flit_q_t stream, cur, exp_flat;
    bit exp_err = 1'b0;
    int n_exp;
    do_reset();
    for (int p = 0; p < 24; p++) begin
      int r = $urandom_range(0, 7);
      if (r == 0) stream.push_back({1'b0, 7'($urandom)});
      else begin
        int len = PKT_LEN;
        if (r == 1) len = 1 + $urandom_range(0, PKT_LEN - 2);
        stream.push_back({1'b1, 4'($urandom), 3'($urandom)});
        for (int i = 1; i < len; i++) stream.push_back({1'b0, 7'($urandom)});
      end
    end
    stream.push_back({1'b1, 7'($urandom)});
    for (int i = 1; i < PKT_LEN; i++) stream.push_back({1'b0, 7'($urandom)});

    foreach (stream[i]) begin
      logic [7:0] f = stream[i];
      if (cur.size() == 0) begin
        if (f[7]) cur.push_back(f); else exp_err = 1'b1;
      end else if (f[7]) begin
        exp_err = 1'b1;
        cur.delete();
        cur.push_back(f);
      end else begin
        cur.push_back(f);
        if (cur.size() == PKT_LEN) begin
          foreach (cur[k]) exp_flat.push_back(cur[k]);
          cur.delete();
        end
      end
    end
    n_exp = exp_flat.size() / PKT_LEN;

    fork
      begin
        bit ok;
        foreach (stream[i]) begin
          send_flit(stream[i], 300, ok);
          vectors++;
          if (!ok) begin miscompares++; $display("FAIL rnd_ack: flit %0d not acked, required ack", i); break; end
        end
      end
      begin
        for (int p = 0; p < n_exp; p++) begin
          bit got = 1'b0;
          for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (sw_req === 1'b1) begin got = 1'b1; break; end
          end
          vectors++;
          if (!got) begin miscompares++; $display("FAIL rnd_req: packet %0d sw_req=0 required 1", p); break; end
          vectors++;
          if (sw_chnl !== exp_flat[p * PKT_LEN][2:0]) begin
            miscompares++;
            $display("FAIL rnd_chnl: packet %0d got %0d required %0d", p, sw_chnl, exp_flat[p * PKT_LEN][2:0]);
          end
          repeat ($urandom_range(0, 4)) @(negedge clk);
          pulse_gnt();
          read_pkt();
          for (int a = 0; a < PKT_LEN; a++) begin
            vectors++;
            if (rd_buf[a] !== exp_flat[p * PKT_LEN + a]) begin
              miscompares++;
              $display("FAIL rnd_data: packet %0d flit %0d got %h required %h", p, a, rd_buf[a], exp_flat[p * PKT_LEN + a]);
            end
          end
          repeat ($urandom_range(0, 4)) @(negedge clk);
          pulse_done();
        end
      end
    join
    repeat (3) @(negedge clk);
    vectors++;
    if (err !== exp_err || sw_req !== 1'b0) begin
      miscompares++; $display("FAIL rnd_final: err=%b req=%b required %b 0", err, sw_req, exp_err);
    end
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_backpressure();
    test_bad_header();
    test_abandon();
    test_reset_midstream();
    test_ignored_handshake();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
